// File: rtl/nn_cls_pkg.sv
// Shared constants and FSM encoding for the class-score argmax controller.
package nn_cls_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int SCORE_W_DEF     = 26;
  // Wide enough for up to 16 classes; also the width of the Img_Num port.
  localparam int CLS_IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/score_cmp.sv
// Signed greater-than compare between an incoming score and the running max.
module score_cmp #(
  parameter int SCORE_W = 26
) (
  input  logic signed [SCORE_W-1:0] a,
  input  logic signed [SCORE_W-1:0] b,
  output logic                      gt
);

  // Both operands are signed, so this is a two's-complement compare.
  assign gt = (a > b);

endmodule

// File: rtl/score_argmax_controller.sv
// Streams NUM_CLASSES signed scores per frame and reports the index and
// value of the largest one. Ties keep the lower index.
module score_argmax_controller
  import nn_cls_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [SCORE_W-1:0] in_score,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CLS_IDX_W-1:0]      Img_Num,
  output logic signed [SCORE_W-1:0] max_score,
  output logic                      busy
);

  localparam logic [CLS_IDX_W-1:0] LAST_IDX = CLS_IDX_W'(NUM_CLASSES - 1);

  state_t                      state;
  logic [CLS_IDX_W-1:0]        idx_cnt;
  logic [CLS_IDX_W-1:0]        run_idx;
  logic signed [SCORE_W-1:0]   run_max;
  logic                        gt;
  logic                        xfer;
  logic [CLS_IDX_W-1:0]        cand_idx;
  logic signed [SCORE_W-1:0]   cand_max;

  // DONE is the only state that refuses scores; this is the backpressure path.
  assign in_ready = (state != DONE);
  assign xfer     = in_valid & in_ready;

  score_cmp #(.SCORE_W(SCORE_W)) u_cmp (
    .a  (in_score),
    .b  (run_max),
    .gt (gt)
  );

  // Strict greater-than: an equal later score never displaces the earlier one.
  assign cand_idx = gt ? idx_cnt  : run_idx;
  assign cand_max = gt ? in_score : run_max;

  // Frame FSM with registered result outputs; clear overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx_cnt   <= '0;
      run_idx   <= '0;
      run_max   <= '0;
      out_valid <= 1'b0;
      Img_Num   <= '0;
      max_score <= '0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      idx_cnt   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            run_max <= in_score;
            run_idx <= '0;
            idx_cnt <= CLS_IDX_W'(1);
            state   <= ACCUM;
            busy    <= 1'b1;
          end
        end
        ACCUM: begin
          if (xfer) begin
            run_max <= cand_max;
            run_idx <= cand_idx;
            if (idx_cnt == LAST_IDX) begin
              // Last class: publish the result; counter parks at zero.
              idx_cnt   <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
              Img_Num   <= cand_idx;
              max_score <= cand_max;
            end else begin
              idx_cnt <= idx_cnt + CLS_IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_argmax_controller.sv
// Directed bench for score_argmax_controller with an expected-result queue.
module tb_score_argmax_controller;

  localparam int NC = 10;
  localparam int SW = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_score;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    Img_Num;
  logic [SW-1:0] max_score;
  logic          busy;

  typedef struct {
    logic [3:0]    idx;
    logic [SW-1:0] mx;
  } res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   fr[NC];

  score_argmax_controller #(.NUM_CLASSES(NC), .SCORE_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_score  (in_score),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Img_Num   (Img_Num),
    .max_score (max_score),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the reference argmax, then stream the frame (optional idle gap).
  task automatic send_frame(input int s[NC], input int gap_at, input bit keep_valid);
    res_t r;
    int   best;
    best  = s[0];
    r.idx = 4'd0;
    for (int i = 1; i < NC; i++) begin
      if (s[i] > best) begin
        best  = s[i];
        r.idx = i[3:0];
      end
    end
    r.mx = best[SW-1:0];
    sb.push_back(r);
    for (int i = 0; i < NC; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        step();
        chk("gap_busy", busy, 1);
        chk("gap_no_out", out_valid, 0);
      end
      in_valid = 1'b1;
      in_score = s[i][SW-1:0];
      step();
      if (i < NC - 1) chk("no_early_out", out_valid, 0);
    end
    in_valid = keep_valid;
  endtask

  task automatic expect_result(input string tag);
    res_t r;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_queue: observed empty expected one entry", tag);
    end else begin
      r = sb.pop_front();
      chk({tag, "_idx"}, Img_Num, r.idx);
      chk({tag, "_max"}, max_score, r.mx);
    end
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_score = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_img", Img_Num, 0);
    chk("rst_max", max_score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    rst = 1'b1;
    step();

    // Mixed scores, continuous handshake.
    fr = '{5, -3, 7, 2, 0, 1, 9, 4, -8, 6};
    send_frame(fr, -1, 1'b0);
    expect_result("fa");
    chk("fa_idx_abs", Img_Num, 6);
    chk("fa_max_abs", max_score, 9);
    step();
    chk("fa_post_valid", out_valid, 0);
    chk("fa_post_busy", busy, 0);
    chk("fa_post_img_held", Img_Num, 6);
    chk("fa_post_in_ready", in_ready, 1);

    // All equal: lowest index wins; includes a mid-frame stall.
    fr = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -100};
    send_frame(fr, 3, 1'b0);
    expect_result("tie");
    chk("tie_idx_abs", Img_Num, 0);
    chk("tie_max_abs", max_score, 26'h3FFFF9C);
    step();

    // Extreme signed values.
    fr = '{-33554432, -33554432, -33554432, -33554432, -33554432,
           -33554432, -33554432, -33554432, -33554432, 33554431};
    send_frame(fr, -1, 1'b0);
    expect_result("ext");
    chk("ext_idx_abs", Img_Num, 9);
    chk("ext_max_abs", max_score, 26'h1FFFFFF);
    step();

    // Output backpressure with input still offered.
    out_ready = 1'b0;
    fr = '{5, -3, 7, 2, 0, 1, 9, 4, -8, 6};
    send_frame(fr, -1, 1'b1);
    expect_result("bp");
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_img", Img_Num, 6);
      chk("bp_max", max_score, 9);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_hs_valid", out_valid, 0);
    chk("bp_hs_busy", busy, 0);

    // Abort after 4 transfers; clear coincides with an offered score.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_score = 26'd1000;
      step();
    end
    clear = 1'b1;
    in_score = 26'd2000;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_valid", out_valid, 0);
    step();
    chk("clr_idle_valid", out_valid, 0);
    fr = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_frame(fr, -1, 1'b0);
    expect_result("ramp");
    chk("ramp_idx_abs", Img_Num, 9);
    chk("ramp_max_abs", max_score, 10);
    step();

    // Clear discards a pending result.
    out_ready = 1'b0;
    fr = '{5, -3, 7, 2, 0, 1, 9, 4, -8, 6};
    send_frame(fr, -1, 1'b0);
    expect_result("pend");
    clear = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b1;
    chk("pend_clr_valid", out_valid, 0);
    chk("pend_clr_busy", busy, 0);
    chk("pend_clr_in_ready", in_ready, 1);

    // Asynchronous reset between edges mid-frame.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_score = fr[i][SW-1:0];
      step();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_img", Img_Num, 0);
    chk("arst_max", max_score, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    chk("arst_rel_in_ready", in_ready, 1);
    chk("arst_rel_valid", out_valid, 0);
    chk("arst_rel_busy", busy, 0);
    send_frame(fr, -1, 1'b0);
    expect_result("post_rst");
    step();
    chk("post_rst_valid", out_valid, 0);

    chk("queue_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_argmax_controller.md
SCORE_ARGMAX_CONTROLLER -- requirements
Module: score_argmax_controller

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of class scores per frame (2..16).
REQ-002 SHALL have parameter SCORE_W, default 26, width of a signed two's-complement score.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous frame abort.
REQ-006 SHALL have port in_valid  input  1  score present on in_score.
REQ-007 SHALL have port in_ready  output  1  controller accepts a score this cycle.
REQ-008 SHALL have port in_score  input  SCORE_W  signed class score, in class-index order 0..NUM_CLASSES-1.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port Img_Num  output  4  index of the winning class.
REQ-012 SHALL have port max_score  output  SCORE_W  winning score.
REQ-013 SHALL have port busy  output  1  frame in progress (state not IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 SHALL define a score transfer as in_valid and in_ready high on the same rising edge.
REQ-016 SHALL drive in_ready high in IDLE and ACCUM, and low in DONE.
REQ-017 SHALL, in IDLE on a transfer, load the running max with in_score and the running index with 0, set idx_cnt to 1, and go to ACCUM.
REQ-018 SHALL, in ACCUM on a transfer, replace the running max and index with in_score and idx_cnt only if in_score is signed-greater than the running max, then increment idx_cnt.
REQ-019 SHALL resolve equal scores to the lower index, because a later score of equal value does not replace the running max.
REQ-020 SHALL move to DONE on the transfer of class NUM_CLASSES-1, with out_valid high in the following cycle, so latency is 1 cycle from the last transfer.
REQ-021 SHALL hold Img_Num and max_score stable while out_valid is high.
REQ-022 SHALL, in DONE, return to IDLE with out_valid low on the cycle out_valid and out_ready are both high; with out_ready held high, the controller completes one frame per NUM_CLASSES+1 cycles.
REQ-023 SHALL otherwise hold in DONE indefinitely, with backpressure to the input through in_ready low.
REQ-024 SHALL leave state unchanged in any cycle with no transfer, including in_valid low mid-frame.
REQ-025 SHALL, when clear is high, go to IDLE next cycle, zero idx_cnt, and drop out_valid, discarding any partial or pending result.
REQ-026 SHALL give clear priority over a simultaneous transfer or output handshake.
REQ-027 SHALL use a wrap-free idx_cnt: it never exceeds NUM_CLASSES-1, and no transfer is possible in DONE.
REQ-028 SHALL drive Img_Num to the 4-bit zero-extended index and leave it unchanged after a handshake until the next result.

Reset
REQ-029 SHALL, while rst is low, asynchronously force state to IDLE and clear to zero: idx_cnt, running max, running index, out_valid, Img_Num, max_score and busy; in_ready is then 1.
REQ-030 SHALL, on reset asserted mid-frame or in DONE, abandon the frame, with no result emitted after release.
REQ-031 SHALL leave rst release synchronous to clk by the system reset synchronizer; the block adds no synchronizer.

Structure
REQ-032 SHALL place NUM_CLASSES and SCORE_W defaults, the FSM state encoding (2-bit: IDLE=0, ACCUM=1, DONE=2) and the class-index width constant in shared package nn_cls_pkg.
REQ-033 SHALL implement the signed greater-than compare in one sub-module, score_cmp, parameterised by SCORE_W, giving a purely combinational gt flag.
REQ-034 SHALL register all outputs except in_ready, which is decoded from state.

Verification
REQ-035 SHALL cover: scores 5,-3,7,2,0,1,9,4,-8,6 back-to-back with out_ready=1 -> Img_Num=6, max_score=9, out_valid one cycle after 10th transfer.
REQ-036 SHALL cover: all ten scores = -100 -> Img_Num=0 (tie to lowest index), max_score=-100.
REQ-037 SHALL cover: scores with class 9 = 0x1FFFFFF and others 0x2000000 (most negative) -> Img_Num=9; signed compare confirmed.
REQ-038 SHALL cover: out_ready low for 5 cycles after result while in_valid held high -> in_ready=0, result stable, no score consumed until handshake.
REQ-039 SHALL cover: clear pulsed after 4th transfer, then a full new frame 1..10 -> Img_Num=9, with no output from the aborted frame.
REQ-040 SHALL cover: rst low asynchronously mid-ACCUM (between edges) -> outputs zero immediately, in_ready=1 after release, next full frame correct.
